// File: rtl/pw_detect_pkg.sv
// Shared types and constants for the multi-channel LED pulse stretcher.
// Default timing assumes a 50 MHz clkin: 1 s hold and 0.5 s group window.
package pw_detect_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } win_state_e;

    localparam int DEFAULT_HOLD_CYCLES   = 50_000_000;
    localparam int DEFAULT_WINDOW_CYCLES = 25_000_000;

    // Bits needed for a down-counter that is loaded with max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/pw_chan_stretch.sv
// One channel: synchroniser and rise detector, followed by a hold counter
// that keeps the LED lit for HOLD_CYCLES cycles after each press.
module pw_chan_stretch
    import pw_detect_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int RETRIGGER   = 1
) (
    input  logic clkin,
    input  logic reset,
    input  logic btn,
    input  logic clr,
    output logic rise,
    output logic led
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    // Stages 0-1 resolve metastability; stages 2-3 feed the edge compare.
    logic [3:0]        sync;
    logic [HOLD_W-1:0] cnt;
    logic              load;

    always_ff @(posedge clkin) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[2:0], btn};
        end
    end

    assign rise = sync[2] & ~sync[3];
    assign load = rise && ((RETRIGGER != 0) || (cnt == '0));

    // A group clear wins over a reload landing on the same edge.
    always_ff @(posedge clkin) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= HOLD_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - HOLD_W'(1);
        end
    end

    assign led = (cnt != '0);

endmodule

// File: rtl/pw_multi_led_timer.sv
// N-channel pushbutton pulse stretcher with a shared group-press window;
// when every channel presses inside one window, all_hit pulses and LEDs clear.
module pw_multi_led_timer
    import pw_detect_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int WINDOW_CYCLES = DEFAULT_WINDOW_CYCLES,
    parameter int RETRIGGER     = 1,
    parameter int CLEAR_ON_ALL  = 1
) (
    input  logic            clkin,
    input  logic            reset,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] led,
    output logic            win_open,
    output logic            all_hit,
    output logic [N_CH-1:0] hit_mask
);

    localparam int WIN_W = cnt_width(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(WINDOW_CYCLES);

    win_state_e       state, state_next;
    logic [WIN_W-1:0] wcnt, wcnt_next;
    logic [N_CH-1:0]  mask, mask_next;
    logic [N_CH-1:0]  rise;
    logic             close_now;
    logic             group_hit;
    logic             clr_all;

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        pw_chan_stretch #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .RETRIGGER   (RETRIGGER)
        ) u_chan (
            .clkin (clkin),
            .reset (reset),
            .btn   (btn[c]),
            .clr   (clr_all),
            .rise  (rise[c]),
            .led   (led[c])
        );
    end

    // Rises on the closing cycle still count, but cannot reopen a window.
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        mask_next  = mask;
        close_now  = 1'b0;
        case (state)
            IDLE: begin
                if (|rise) begin
                    state_next = OPEN;
                    wcnt_next  = WIN_LOAD;
                    mask_next  = rise;
                end
            end
            OPEN: begin
                mask_next = mask | rise;
                wcnt_next = wcnt - WIN_W'(1);
                if (wcnt == WIN_W'(1)) begin
                    close_now  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign group_hit = close_now && (&mask_next);
    assign clr_all   = group_hit && (CLEAR_ON_ALL != 0);

    always_ff @(posedge clkin) begin
        if (reset) begin
            state    <= IDLE;
            wcnt     <= '0;
            mask     <= '0;
            hit_mask <= '0;
            all_hit  <= 1'b0;
        end else begin
            state   <= state_next;
            wcnt    <= wcnt_next;
            mask    <= mask_next;
            all_hit <= group_hit;
            if (close_now) begin
                hit_mask <= mask_next;
            end
        end
    end

    assign win_open = (state == OPEN);

endmodule
